// File: rtl/uart_tx_port.sv
// uart_tx_port: byte-buffered UART transmitter.
// A small FIFO feeds an IDLE/START/DATA/STOP frame engine. Frames go back to
// back while the FIFO holds data, and serial_tx idles high.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11 bit periods per frame).
// Without it, frames are 8N1 (10 bit periods per frame).
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic [7:0] txdata,
  input  logic       txclk,
  output logic       txready,
  output logic       serial_tx,
  output logic       busy,
  output logic       overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } TxState;

  TxState            r_state;
  TxState            w_nextState;
  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_baud;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_overflow;
`ifdef UART_TX_PARITY_EN
  logic              r_parity;
`endif
  logic              w_push;
  logic              w_pop;
  logic              w_baudDone;

  assign txready    = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push     = txclk & txready;
  assign w_baudDone = (r_baud == 16'(CLKS_PER_BIT - 1));
  assign serial_tx  = r_tx;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE) | (r_count != '0);

  // Frame sequencing: decide the next state and whether the head byte is popped
  // this edge. A pop happens on leaving IDLE or at the end of STOP, so back-to-back
  // frames chain with no idle gap.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_nextState = START;
        end
      end
      START: begin
        if (w_baudDone) w_nextState = DATA;
      end
      DATA: begin
        if (w_baudDone && (r_bitIdx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          w_nextState = PARITY;
`else
          w_nextState = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_baudDone) w_nextState = STOP;
      end
`endif
      STOP: begin
        if (w_baudDone) begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_nextState = START;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register; reset aborts any frame in progress.
  always_ff @(posedge hwclk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // FIFO storage: no reset needed because the pointers and count define validity.
  always_ff @(posedge hwclk) begin
    if (!reset && w_push) r_mem[r_wrPtr] <= txdata;
  end

  // FIFO bookkeeping, baud timing, shifter and the registered line driver.
  // The line register follows the current state, so serial_tx lags a state
  // change by one cycle. Every bit still lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_baud     <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (txclk && !txready) r_overflow <= 1'b1;
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + PTR_W'(1);
        r_shift  <= r_mem[r_rdPtr];
        r_bitIdx <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity <= ^r_mem[r_rdPtr];
`endif
      end else if ((r_state == DATA) && w_baudDone) begin
        r_shift  <= r_shift >> 1;
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if ((r_state == IDLE) || (w_nextState != r_state) || w_baudDone) r_baud <= '0;
      else r_baud <= r_baud + 16'd1;
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  r_tx <= r_parity;
`endif
        default: r_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed self-checking bench for uart_tx_port.
// It runs the design with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Define UART_TX_PARITY_EN for both the bench and the design to also run the
// parity cases.
module tb_uart_tx_port;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = CPB * NBITS;

  logic       hwclk;
  logic       reset;
  logic [7:0] txdata;
  logic       txclk;
  logic       txready;
  logic       serial_tx;
  logic       busy;
  logic       overflow;

  int checks;
  int failures;

  uart_tx_port #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .hwclk    (hwclk),
    .reset    (reset),
    .txdata   (txdata),
    .txclk    (txclk),
    .txready  (txready),
    .serial_tx(serial_tx),
    .busy     (busy),
    .overflow (overflow)
  );

  // Free-running clock with a 10 ns period.
  always #5 hwclk = ~hwclk;

  // Advance one rising edge, then settle 1 ns past it for sampling and driving.
  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one txclk/txdata pair for exactly one edge.
  task automatic applyStimulus(input logic strobe, input logic [7:0] data);
    txclk  = strobe;
    txdata = data;
    tick();
    txclk  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_serial_tx", serial_tx, 1'b1);
    checkOutput("rst_txready", txready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overflow", overflow, 1'b0);
  endtask

  // Call just after the edge where bit firstBit of the frame begins on the line.
  // Each bit is checked in its second cycle, and the task returns at the edge
  // where the following bit period would begin.
  task automatic checkFrame(input logic [7:0] data, input int firstBit);
    logic [NBITS-1:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = data;
`ifdef UART_TX_PARITY_EN
    bits[9]   = ^data;
`endif
    bits[NBITS-1] = 1'b1;
    for (int k = firstBit; k < NBITS; k++) begin
      tick();
      checkOutput($sformatf("frame%02h_bit%0d", data, k), serial_tx, bits[k]);
      checkOutput($sformatf("frame%02h_busy%0d", data, k), busy, 1'b1);
      waitCycles(CPB - 1);
    end
  endtask

  initial begin
    hwclk    = 1'b0;
    reset    = 1'b1;
    txclk    = 1'b0;
    txdata   = 8'h00;
    checks   = 0;
    failures = 0;

    $display("[TB] reset state");
    doReset();

    $display("[TB] single byte 0xA5, latency and frame");
    applyStimulus(1'b1, 8'hA5);
    checkOutput("a5_txready", txready, 1'b1);
    checkOutput("a5_busy", busy, 1'b1);
    checkOutput("a5_line_n0", serial_tx, 1'b1);
    tick();
    checkOutput("a5_line_n1", serial_tx, 1'b1);
    tick();
    checkOutput("a5_line_n2", serial_tx, 1'b0);
    checkFrame(8'hA5, 0);
    checkOutput("a5_busy_end", busy, 1'b0);
    checkOutput("a5_line_end", serial_tx, 1'b1);

    $display("[TB] three back-to-back bytes");
    applyStimulus(1'b1, 8'h01);
    checkOutput("b2b_txready0", txready, 1'b1);
    applyStimulus(1'b1, 8'h02);
    checkOutput("b2b_txready1", txready, 1'b1);
    applyStimulus(1'b1, 8'h03);
    checkOutput("b2b_txready2", txready, 1'b1);
    checkOutput("b2b_start", serial_tx, 1'b0);
    checkFrame(8'h01, 0);
    checkFrame(8'h02, 0);
    checkFrame(8'h03, 0);
    checkOutput("b2b_busy_end", busy, 1'b0);
    checkOutput("b2b_line_end", serial_tx, 1'b1);

    $display("[TB] six writes, sixth overflows");
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    checkOutput("ovf_txready_hi", txready, 1'b1);
    applyStimulus(1'b1, 8'h55);
    checkOutput("ovf_txready_full", txready, 1'b0);
    checkOutput("ovf_flag_before", overflow, 1'b0);
    applyStimulus(1'b1, 8'h66);
    checkOutput("ovf_flag_set", overflow, 1'b1);
    checkOutput("ovf_txready_still", txready, 1'b0);
    tick();
    checkFrame(8'h11, 1);
    checkFrame(8'h22, 0);
    checkFrame(8'h33, 0);
    checkFrame(8'h44, 0);
    checkFrame(8'h55, 0);
    checkOutput("ovf_busy_end", busy, 1'b0);
    waitCycles(2 * FRAME);
    checkOutput("ovf_no_sixth", serial_tx, 1'b1);
    checkOutput("ovf_sticky", overflow, 1'b1);

    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'hBB);
    waitCycles(13);
    checkOutput("mid_bit2", serial_tx, 1'b1);
    checkOutput("mid_busy", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_line", serial_tx, 1'b1);
    checkOutput("mid_txready", txready, 1'b1);
    checkOutput("mid_busy_after", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      waitCycles(5);
      checkOutput($sformatf("mid_quiet%0d", i), serial_tx, 1'b1);
    end
    checkOutput("mid_quiet_busy", busy, 1'b0);

    $display("[TB] txclk ignored during reset");
    reset = 1'b1;
    txclk = 1'b1;
    txdata = 8'h5A;
    tick();
    reset = 1'b0;
    txclk = 1'b0;
    checkOutput("rstw_busy", busy, 1'b0);
    waitCycles(3);
    checkOutput("rstw_line", serial_tx, 1'b1);
    checkOutput("rstw_busy_later", busy, 1'b0);

    $display("[TB] write on STOP-end pop edge while full");
    doReset();
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hC2);
    applyStimulus(1'b1, 8'hC3);
    applyStimulus(1'b1, 8'hC4);
    applyStimulus(1'b1, 8'hC5);
    waitCycles(FRAME - 4);
    checkOutput("pop_txready_full", txready, 1'b0);
    checkOutput("pop_overflow_pre", overflow, 1'b0);
    applyStimulus(1'b1, 8'hEE);
    checkOutput("pop_overflow", overflow, 1'b1);
    checkOutput("pop_txready_after", txready, 1'b1);
    tick();
    checkFrame(8'hC2, 0);
    checkFrame(8'hC3, 0);
    checkFrame(8'hC4, 0);
    checkFrame(8'hC5, 0);
    checkOutput("pop_busy_end", busy, 1'b0);
    waitCycles(FRAME);
    checkOutput("pop_no_ee", serial_tx, 1'b1);

`ifdef UART_TX_PARITY_EN
    $display("[TB] parity frames");
    doReset();
    applyStimulus(1'b1, 8'h07);
    waitCycles(2);
    checkOutput("par07_start", serial_tx, 1'b0);
    checkFrame(8'h07, 0);
    checkOutput("par07_busy_end", busy, 1'b0);
    applyStimulus(1'b1, 8'h03);
    waitCycles(2);
    checkOutput("par03_start", serial_tx, 1'b0);
    waitCycles(1 + 9 * CPB);
    checkOutput("par03_parity_bit", serial_tx, 1'b0);
    waitCycles(CPB);
    checkOutput("par03_stop_bit", serial_tx, 1'b1);
    waitCycles(CPB - 2);
    checkOutput("par03_busy_end", busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, giving hwclk cycles per serial bit (12 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the byte-buffer entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port hwclk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port txdata, input, 8 bits: byte to enqueue.
REQ-006 SHALL have port txclk, input, 1 bit: one-cycle write strobe for txdata.
REQ-007 SHALL have port txready, output, 1 bit: high when the FIFO can accept a byte.
REQ-008 SHALL have port serial_tx, output, 1 bit: UART line; idle high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag for a write attempted while full.

Function
REQ-011 SHALL derive txready combinationally from the registered count, as count < FIFO_DEPTH.
REQ-012 SHALL accept a byte at an edge only when txclk=1 and txready=1 at that edge.
REQ-013 SHALL ignore txclk=1 with txready=0, leave the FIFO unchanged, and set overflow=1 at that edge.
REQ-014 SHALL clear overflow only on reset.
REQ-015 SHALL keep count unchanged on a simultaneous push and pop.
REQ-016 SHALL not let a same-edge pop make room for a write when count=FIFO_DEPTH; that write is rejected per REQ-013.
REQ-017 SHALL wrap FIFO pointers modulo FIFO_DEPTH and emit bytes in write order.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY (only when the macro is defined) and STOP.
REQ-019 SHALL pop the head byte into the shift register and enter START on the IDLE edge where count>0.
REQ-020 SHALL drive serial_tx from a register: 0 in START, the data bit LSB first in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-021 SHALL hold each state for exactly CLKS_PER_BIT cycles using a baud counter that reloads on every state change.
REQ-022 SHALL stay in DATA for 8 bit periods, tracked by a 3-bit index.
REQ-023 SHALL, at STOP end, go to START directly (popping in the same edge) if count>0, otherwise to IDLE, so back-to-back frames have no idle gap.
REQ-024 SHALL give a 2-cycle latency on an idle, empty block: write accepted at edge N, pop at edge N+1, serial_tx=0 after edge N+2.
REQ-025 SHALL compute busy = (state!=IDLE) | (count!=0).
REQ-026 SHALL ignore txdata while txclk=0.

Reset
REQ-027 SHALL, on the first edge with reset=1, set state=IDLE, serial_tx=1, count=0, both pointers=0, baud counter=0, bit index=0 and overflow=0, giving txready=1 and busy=0.
REQ-028 SHALL, when reset is asserted mid-frame, abort the frame, force serial_tx high on the next edge and discard all FIFO contents.
REQ-029 SHALL ignore txclk on any edge where reset=1.

Configuration
REQ-030 SHALL, when macro UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP that sends the even parity of the 8 data bits for CLKS_PER_BIT cycles (frame = 11 bit periods).
REQ-031 SHALL, when UART_TX_PARITY_EN is undefined, have no PARITY state and send 8N1 frames of 10 bit periods.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 SHALL cover: write 0xA5 while idle -> serial_tx low 2 cycles after the write edge, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy falls after 40 cycles of frame.
REQ-033 SHALL cover: write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous frames in order with no idle gap; txready stays 1.
REQ-034 SHALL cover: 5 writes on consecutive cycles while the first frame is active -> bytes 1-5 all accepted (one pops at the second edge); a 6th write gets txready=0 and is dropped, overflow=1; the line carries only bytes 1-5.
REQ-035 SHALL cover: reset asserted in the 3rd data bit of 0xFF with 2 bytes queued -> serial_tx=1, txready=1, busy=0 the next cycle, and no further frames.
REQ-036 SHALL cover: with UART_TX_PARITY_EN, write 0x07 -> parity bit 1, then stop; write 0x03 -> parity bit 0; frame 44 cycles.
REQ-037 SHALL cover: with count=4 and STOP ending, pulse txclk on the pop edge -> write rejected and overflow=1.
